// File: rtl/alib_range_image_reader.sv
// Row-major frame reader for the range-image buffer RAM: hides the 1-cycle read latency
// and absorbs backpressure with a 2-entry buffer. Define ALIB_RANGE_IMAGE_READER_CLEAR_ON_READ_EN to zero pixels as they are read.
module alib_range_image_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 524288,
    parameter int ROWS       = 64,
    parameter int COLS       = 2048,
    localparam int AW        = $clog2(DEPTH-1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         ram_addrb,
    output logic                  ram_rd_en,
    input  logic [DATA_WIDTH-1:0] ram_dout,
`ifdef ALIB_RANGE_IMAGE_READER_CLEAR_ON_READ_EN
    output logic [AW-1:0]         ram_addra,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
`endif
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_frame_end
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                state;
    logic [RW-1:0]         row;
    logic [CW-1:0]         col;
    logic [1:0]            count;
    logic                  vld_p1;
    logic                  last_p1;
    logic                  fe_p1;
    logic [DATA_WIDTH-1:0] head_data, tail_data;
    logic                  head_last, tail_last;
    logic                  head_fe, tail_fe;
    logic                  pop;
    logic                  issue;
    logic                  col_end;
    logic                  final_addr;
    logic [2:0]            occ_nxt;

    // occ_nxt is the occupancy the buffer will have once this cycle's push/pop settle
    assign pop        = m_valid & m_ready;
    assign occ_nxt    = {1'b0, count} + {2'b00, vld_p1} - {2'b00, pop};
    assign issue      = (state == READ) && (occ_nxt < 3'd2);
    assign col_end    = (col == CW'(COLS-1));
    assign final_addr = col_end && (row == RW'(ROWS-1));

    assign ram_rd_en   = issue;
    assign m_valid     = (count != 2'd0);
    assign m_data      = head_data;
    assign m_last      = head_last;
    assign m_frame_end = head_fe;

`ifdef ALIB_RANGE_IMAGE_READER_CLEAR_ON_READ_EN
    assign ram_we    = issue;
    assign ram_addra = ram_addrb;
    assign ram_din   = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_addrb <= '0;
            row       <= '0;
            col       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // a start coinciding with the done pulse belongs to the finished frame
                    if (start && !done) begin
                        state     <= READ;
                        busy      <= 1'b1;
                        ram_addrb <= '0;
                        row       <= '0;
                        col       <= '0;
                    end
                end
                READ: begin
                    if (issue) begin
                        if (final_addr) begin
                            state <= DRAIN;
                        end else begin
                            ram_addrb <= ram_addrb + 1'b1;
                            if (col_end) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (occ_nxt == 3'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // stage p1: read in flight, tags travel with it until ram_dout is valid
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            fe_p1     <= 1'b0;
            count     <= 2'd0;
            head_data <= '0;
            head_last <= 1'b0;
            head_fe   <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
            tail_fe   <= 1'b0;
        end else begin
            vld_p1  <= issue;
            last_p1 <= col_end;
            fe_p1   <= final_addr;
            // stage p2: capture into the 2-entry output buffer
            case ({vld_p1, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_data <= ram_dout;
                        head_last <= last_p1;
                        head_fe   <= fe_p1;
                    end else begin
                        tail_data <= ram_dout;
                        tail_last <= last_p1;
                        tail_fe   <= fe_p1;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_last <= tail_last;
                    head_fe   <= tail_fe;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_data <= ram_dout;
                        head_last <= last_p1;
                        head_fe   <= fe_p1;
                    end else begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        head_fe   <= tail_fe;
                        tail_data <= ram_dout;
                        tail_last <= last_p1;
                        tail_fe   <= fe_p1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alib_range_image_reader.sv
// Bench for alib_range_image_reader: a 2x3 image read through a RAM model, checked against
// an expected pixel stream derived from the image contents.
module tb_alib_range_image_reader;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int ROWS  = 2;
    localparam int COLS  = 3;
    localparam int N     = ROWS * COLS;
    localparam int AW    = $clog2(DEPTH-1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addrb;
    logic          ram_rd_en;
    logic [DW-1:0] ram_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_frame_end;
`ifdef ALIB_RANGE_IMAGE_READER_CLEAR_ON_READ_EN
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_din;
    logic          ram_we;
`endif

    always #5 clk = ~clk;

    alib_range_image_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ram_addrb(ram_addrb), .ram_rd_en(ram_rd_en), .ram_dout(ram_dout),
`ifdef ALIB_RANGE_IMAGE_READER_CLEAR_ON_READ_EN
        .ram_addra(ram_addra), .ram_din(ram_din), .ram_we(ram_we),
`endif
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .m_frame_end(m_frame_end)
    );

    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   img [N];
    logic [DW+1:0]   exp_q [$];
    int              checks = 0;
    int              errors = 0;
    int              issued, accepted, done_cnt, cyc, first_acc, last_acc;
    bit              fe_prev, prev_stall;
    logic [DW-1:0]   sv_data;
    logic            sv_last, sv_fe;

    // RAM model: registered read port; the optional clear port writes after the read (read-before-write)
    always @(posedge clk) begin
        if (ram_rd_en) ram_dout <= mem[ram_addrb];
`ifdef ALIB_RANGE_IMAGE_READER_CLEAR_ON_READ_EN
        if (ram_we) mem[ram_addra] = ram_din;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input bit rnd);
        for (int i = 0; i < DEPTH; i++) mem[i] = rnd ? DW'($urandom) : DW'(i + 100);
        for (int i = 0; i < N; i++) img[i] = mem[i];
    endtask

    // expected stream: pixel i of the image, last at each row end, frame_end on the final pixel
    task automatic start_frame();
        exp_q.delete();
        for (int i = 0; i < N; i++)
            exp_q.push_back({img[i], (i % COLS) == COLS-1, i == N-1});
        issued = 0; accepted = 0; done_cnt = 0; fe_prev = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int mode, input int budget);
        bit seen = 0;
        int pat [6] = '{1, 0, 0, 1, 0, 1};
        for (int k = 0; k < budget && !seen; k++) begin
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = 1'(pat[k % 6]);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
        check("pixels_accepted", accepted, N);
        check("stream_complete", exp_q.size(), 0);
`ifdef ALIB_RANGE_IMAGE_READER_CLEAR_ON_READ_EN
        for (int i = 0; i < N; i++) img[i] = '0;
`endif
    endtask

    // monitor: samples mid-cycle and scores every accepted pixel, hold, read and done
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
            fe_prev    = 0;
        end else begin
            cyc++;
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, sv_data);
                check("hold_last", m_last, sv_last);
                check("hold_frame_end", m_frame_end, sv_fe);
            end
            if (done || fe_prev) check("done_timing", done, fe_prev);
            if (done) done_cnt++;
            fe_prev = 0;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_pixel", 1, 0);
                end else begin
                    logic [DW+1:0] e;
                    e = exp_q.pop_front();
                    check("pixel_data", m_data, e[DW+1:2]);
                    check("pixel_last", m_last, e[1]);
                    check("pixel_frame_end", m_frame_end, e[0]);
                    fe_prev = e[0];
                end
                if (accepted == 0) first_acc = cyc;
                last_acc = cyc;
                accepted++;
            end
            if (ram_rd_en) begin
                check("read_addr", ram_addrb, issued);
                issued++;
                check("reads_ahead_le2", (issued - accepted) <= 2, 1);
            end
            if (dut.vld_p1) check("no_capture_when_full", dut.count, (dut.count == 2'd2) ? 3 : dut.count);
`ifdef ALIB_RANGE_IMAGE_READER_CLEAR_ON_READ_EN
            check("clear_we", ram_we, ram_rd_en);
            if (ram_we) begin
                check("clear_addr", ram_addra, ram_addrb);
                check("clear_din", ram_din, 0);
            end
`endif
            prev_stall = m_valid && !m_ready;
            sv_data = m_data; sv_last = m_last; sv_fe = m_frame_end;
        end
    end

    initial begin
        bit found;
        rst = 1'b1; start = 1'b0; m_ready = 1'b0;
        cyc = 0; issued = 0; accepted = 0; done_cnt = 0;
        preload(0);
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addrb", ram_addrb, 0);
        check("rst_rd_en", ram_rd_en, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_last", m_last, 0);
        check("rst_frame_end", m_frame_end, 0);
`ifdef ALIB_RANGE_IMAGE_READER_CLEAR_ON_READ_EN
        check("rst_we", ram_we, 0);
        check("rst_addra", ram_addra, 0);
        check("rst_din", ram_din, 0);
`endif
        rst = 1'b0;
        tick();

        // full-rate frame with latency checks
        m_ready = 1'b1;
        start_frame();
        check("lat_busy", busy, 1);
        check("lat_rd_en", ram_rd_en, 1);
        check("lat_addr0", ram_addrb, 0);
        check("lat_valid_e0", m_valid, 0);
        tick();
        check("lat_valid_e1", m_valid, 0);
        tick();
        check("lat_valid_e2", m_valid, 1);
        check("lat_first_data", m_data, img[0]);
        wait_done(0, 30);
        tick();
        check("full_rate_span", last_acc - first_acc, N - 1);
        check("one_done_a", done_cnt, 1);
        check("idle_after_a", busy, 0);

        // toggling backpressure
        preload(0);
        m_ready = 1'b1;
        start_frame();
        wait_done(1, 60);
        tick();
        check("one_done_b", done_cnt, 1);

        // long stall right after start
        preload(0);
        m_ready = 1'b0;
        start_frame();
        repeat (9) tick();
        check("stall_reads", issued, 2);
        check("stall_count", dut.count, 2);
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, img[0]);
        check("stall_rd_en", ram_rd_en, 0);
        wait_done(0, 30);
        tick();
        check("resume_full_rate", last_acc - first_acc, N - 1);

        // start while busy and in the done cycle is ignored
        preload(0);
        m_ready = 1'b1;
        start_frame();
        for (int k = 0; k < 20 && accepted < 3; k++) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(0, 30);
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        check("restart_ignored_busy", busy, 0);
        check("restart_ignored_done", done_cnt, 1);
        check("restart_ignored_pix", accepted, N);
        check("restart_ignored_rd", issued, N);

        // reset while pixel 2 is presented
        preload(0);
        m_ready = 1'b1;
        start_frame();
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_valid && m_data == img[2]) found = 1;
            else tick();
        end
        check("saw_pixel2", found, 1);
        rst = 1'b1;
        tick();
        check("abort_valid", m_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        exp_q.delete();
        rst = 1'b0;
        done_cnt = 0;
        repeat (4) tick();
        check("abort_no_done", done_cnt, 0);
        preload(0);
        start_frame();
        wait_done(0, 30);
        tick();

        // random images under random backpressure
        for (int f = 0; f < 3; f++) begin
            preload(1);
            m_ready = 1'($urandom_range(0, 1));
            start_frame();
            wait_done(2, 200);
            tick();
            check("rand_one_done", done_cnt, 1);
        end

`ifdef ALIB_RANGE_IMAGE_READER_CLEAR_ON_READ_EN
        // read-and-clear: the second frame sees a zeroed image
        preload(0);
        start_frame();
        wait_done(0, 30);
        tick();
        begin
            int nz = 0;
            for (int i = 0; i < N; i++) if (mem[i] != 0) nz++;
            check("clear_ram_zeroed", nz, 0);
        end
        start_frame();
        wait_done(0, 30);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alib_range_image_reader.md
Name: alib_range_image_reader

Overview:
- Read-side sequencer for the range-image buffer RAM.
- A writer fills the RAM with a ROWS x COLS range image; on a start pulse this block scans it row-major through the RAM's read port and emits each pixel on a valid/ready output stream.
- It hides the RAM's 1-cycle registered read latency and absorbs downstream backpressure with a 2-entry output buffer, sustaining 1 pixel/cycle.

Parameters:
- DATA_WIDTH, 16, pixel width; must match the RAM.
- DEPTH, 524288, RAM depth. Address width AW = $clog2(DEPTH-1).
- ROWS, 64, image rows.
- COLS, 2048, image columns. Requires ROWS*COLS <= DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  frame read request; sampled only in IDLE
- busy  out  1  high in READ and DRAIN
- done  out  1  1-cycle pulse after the final pixel is accepted
- ram_addrb  out  AW  RAM read address
- ram_rd_en  out  1  drives the RAM read-enable/output-reset pin; high while a read is issued
- ram_dout  in  DATA_WIDTH  RAM read data, valid the cycle after issue
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_WIDTH  pixel value
- m_last  out  1  last column of the current row
- m_frame_end  out  1  last pixel of the frame

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, ram_addrb=0, ram_rd_en=0, m_valid=0, m_data=0, m_last=0, m_frame_end=0. The buffer and in-flight flag are cleared.
- Reset mid-frame aborts the frame immediately: no done pulse, and in-flight data is discarded.
- States: IDLE -> READ on start. READ -> DRAIN when the final address (ROWS*COLS-1) has been issued. DRAIN -> IDLE when the buffer is empty and nothing is in flight; done=1 for that one cycle.
- start while busy is ignored. start in the same cycle as the done pulse is ignored.
- Address generation:
  - row/col counters: col wraps COLS-1 -> 0 and increments row.
  - ram_addrb = row*COLS + col, registered; increments by 1 per issued read.
- Issue rule: a read is issued in a cycle iff state=READ and (count + inflight - pop) < 2.
  - count = buffer occupancy (0..2).
  - inflight = a read was issued in the previous cycle.
  - pop = m_valid & m_ready.
- Read data: ram_dout is captured into the buffer the cycle after issue, with the tag bits (last, frame_end) pipelined alongside.
  - A capture while the buffer is full must never occur; the issue rule guarantees this. Verification asserts it.
- Output: m_valid = (count != 0). m_data, m_last and m_frame_end come from the head entry.
  - Outputs are held stable while m_valid & !m_ready.
  - Simultaneous push and pop leaves count unchanged.
- Latency: start sampled at edge E0. Address 0 is presented with ram_rd_en=1 after E0. Data is registered by the RAM at E1 and captured at E2. m_valid=1 first after E2, i.e. 3 cycles after start.
- Throughput: with m_ready held high, one pixel per cycle, no bubbles.
- m_last = 1 when col == COLS-1. m_frame_end = 1 only on address ROWS*COLS-1; m_last is also 1 on that pixel.
- done follows the accept of the frame_end pixel by exactly one cycle.
- Degenerate case ROWS=COLS=1: a single pixel with m_last=1 and m_frame_end=1.

Optional Feature:
- Macro ALIB_RANGE_IMAGE_READER_CLEAR_ON_READ_EN.
- When defined, three extra outputs are added: ram_addra (AW), ram_din (DATA_WIDTH), ram_we (1).
  - In the cycle a read of address A is issued, ram_we=1, ram_addra=A, ram_din=0.
  - The RAM returns the old value for that address (read-before-write on a separate port), and the image is zeroed for the next frame.
  - All three outputs reset to 0.
- When undefined, the ports do not exist and the RAM is never written.

Test Plan:
- ROWS=2, COLS=3; RAM preloaded with addr+100; m_ready=1; start pulse.
  - Response: m_data 100,101,102,103,104,105 on consecutive cycles; first m_valid 3 cycles after start; m_last on 102 and 105; m_frame_end only on 105; done 1 cycle after the 105 accept.
- Same image with m_ready toggling 1,0,0,1,0,1...
  - Response: all 6 values in order, none dropped or duplicated; m_data/m_last held while stalled; ram_addrb never advances more than 2 ahead of accepted pixels.
- m_ready=0 for 10 cycles after start.
  - Response: exactly 2 reads issued (addresses 0,1), count=2, m_data=100 held; after release, the stream resumes at full rate.
- start asserted again at pixel 3 and in the done cycle.
  - Response: ignored; exactly 6 pixels and one done per frame.
- rst asserted while pixel 2 is presented.
  - Response: next cycle m_valid=0, busy=0, no done; a new start reads from address 0 again and yields 100..105.
- With ALIB_RANGE_IMAGE_READER_CLEAR_ON_READ_EN: read one frame, then a second frame.
  - Response: first frame 100..105; ram_we pulses at addresses 0..5 with din=0; second frame all zeros.
